program_loader_tx: RTL and testbench
====================================

// Module: program_loader_tx
// PURPOSE
//   Host-side transmitter for the core programming interface. Takes a byte stream over valid/ready,
//   frames it as PROGRAMMER_RESET / PROGRAMMER_DIN / PROGRAMMER_PCK / PROGRAMMER_SCK strobes, and
//   loads RomDepth bytes into each of NumberOfCores core ROMs in order. Sits between the host link
//   (UART/JTAG bridge) and the multicore top, and holds the cores during download.
// PARAMETERS
//   NumberOfCores  4   cores to program; 1..16
//   RomDepth       16  bytes per core ROM; power of 2, >=2
//   SetupCycles    1   cycles PROGRAMMER_DIN is stable before a PCK/SCK strobe; >=1
//   StrobeWidth    2   cycles PCK/SCK are held high; >=1
//   HoldCycles     1   cycles PROGRAMMER_DIN is held after a strobe falls; >=1
// PORTS
//   CLK                in   1  single clock; all logic on the rising edge
//   PROGLOADER_RESET   in   1  synchronous, active-high reset
//   PROGLOADER_START   in   1  1-cycle request to start a full image download
//   PROGLOADER_ABORT   in   1  cancels a download in progress
//   PROGLOADER_DATA    in   8  host byte
//   PROGLOADER_VALID   in   1  PROGLOADER_DATA is valid
//   PROGLOADER_READY   out  1  loader accepts a byte this cycle
//   PROGLOADER_BUSY    out  1  download in progress (any state except IDLE)
//   PROGLOADER_DONE    out  1  1-cycle pulse when the last byte has been sent
//   CPU_HOLD           out  1  holds the cores; equals PROGLOADER_BUSY
//   PROGRAMMER_RESET   out  1  programmer reset strobe
//   PROGRAMMER_DIN     out  8  byte to the programmer
//   PROGRAMMER_PCK     out  1  byte strobe; the programmer writes DIN to the current ROM address
//   PROGRAMMER_SCK     out  1  core-select strobe; the programmer advances to the next core
// BEHAVIOUR
//   Reset: all outputs are 0 and the FSM is in IDLE. Reset mid-operation aborts on the next edge
//     without a DONE pulse and without a PROGRAMMER_RESET pulse.
//   Registers: all outputs are registered. Byte counter is $clog2(RomDepth) bits; core counter is
//     $clog2(NumberOfCores) bits, min 1.
//   FSM states: IDLE, PRST, WAIT, SETUP, PSTRB, HOLD, SSETUP, SSTRB, SHOLD, FIN.
//   IDLE:
//     START=1 -> PRST; both counters cleared.
//     START is ignored in every other state.
//   PRST: PROGRAMMER_RESET=1 for exactly 2 cycles, then WAIT.
//   WAIT: READY=1. On VALID&READY the byte is latched into PROGRAMMER_DIN -> SETUP.
//     READY is 0 in all other states.
//   SETUP:
//     SetupCycles cycles, then PSTRB.
//     PROGRAMMER_DIN holds the latched byte from SETUP through HOLD.
//   PSTRB: PCK=1 for StrobeWidth cycles, then HOLD.
//   HOLD: HoldCycles cycles, then one of:
//     byte counter != RomDepth-1 -> byte counter +1, WAIT.
//     last byte of a core that is not the last core -> byte counter wraps to 0, SSETUP.
//     last byte of the last core -> FIN.
//   SSETUP/SSTRB/SHOLD: same timing as SETUP/PSTRB/HOLD, with SCK instead of PCK and DIN=0.
//     Then core counter +1, WAIT.
//   FIN: DONE=1 for 1 cycle, then IDLE.
//   Strobes: PCK and SCK are never high in the same cycle. Exactly NumberOfCores-1 SCK pulses and
//     NumberOfCores*RomDepth PCK pulses per image.
//   Per-byte cost with VALID held high: 1 + SetupCycles + StrobeWidth + HoldCycles cycles
//     (5 at defaults).
//   ABORT, in any state except IDLE and FIN -> PRST-style 1-cycle PROGRAMMER_RESET pulse, then IDLE.
//     No DONE pulse; counters cleared. ABORT in FIN is ignored. ABORT together with
//     PROGLOADER_RESET: reset wins.
//   Host stall: VALID low in WAIT keeps the FSM in WAIT indefinitely, with PCK and SCK low.
// TESTING
//   Reset, then START, then 64 bytes 0x00..0x3F with VALID held high:
//     PROGRAMMER_RESET high for 2 cycles.
//     64 PCK pulses, each 2 cycles wide, with DIN equal to the byte.
//     3 SCK pulses, after bytes 0x0F, 0x1F and 0x2F.
//     DONE at one cycle after the last HOLD; 320+ cycles total.
//   VALID toggled randomly: no byte is lost or duplicated, READY is high only in WAIT, and the DIN
//     sequence matches the input.
//   ABORT after byte 20: 1-cycle PROGRAMMER_RESET, no DONE, BUSY=0. A following START restarts
//     at core 0, byte 0.
//   PROGLOADER_RESET asserted during a PSTRB: next cycle all outputs are 0 and the FSM is in IDLE.
//   START pulsed while BUSY: no effect on the strobe count. START in the same cycle as FIN's DONE
//     is ignored.
//   NumberOfCores=1, RomDepth=4: 4 PCK pulses and 0 SCK pulses, then DONE.

Source files
------------

// File: rtl/program_loader_tx.sv
// Frames a host byte stream into PROGRAMMER_* strobes and loads RomDepth bytes into each core ROM.
// All outputs are registered. A byte costs 1+Setup+Strobe+Hold cycles. READY is high only while waiting for a byte.
module program_loader_tx #(
  parameter int NumberOfCores = 4,
  parameter int RomDepth      = 16,
  parameter int SetupCycles   = 1,
  parameter int StrobeWidth   = 2,
  parameter int HoldCycles    = 1
) (
  input  logic       CLK,
  input  logic       PROGLOADER_RESET,
  input  logic       PROGLOADER_START,
  input  logic       PROGLOADER_ABORT,
  input  logic [7:0] PROGLOADER_DATA,
  input  logic       PROGLOADER_VALID,
  output logic       PROGLOADER_READY,
  output logic       PROGLOADER_BUSY,
  output logic       PROGLOADER_DONE,
  output logic       CPU_HOLD,
  output logic       PROGRAMMER_RESET,
  output logic [7:0] PROGRAMMER_DIN,
  output logic       PROGRAMMER_PCK,
  output logic       PROGRAMMER_SCK
);
  localparam int ByteW  = $clog2(RomDepth);
  localparam int CoreW  = (NumberOfCores > 1) ? $clog2(NumberOfCores) : 1;
  localparam int MaxPh0 = (SetupCycles > StrobeWidth) ? SetupCycles : StrobeWidth;
  localparam int MaxPh  = (MaxPh0 > HoldCycles) ? MaxPh0 : HoldCycles;
  localparam int PhW    = (MaxPh > 2) ? $clog2(MaxPh) : 1;

  typedef enum logic [3:0] {
    IDLE, PRST, WAIT, SETUP, PSTRB, HOLD, SSETUP, SSTRB, SHOLD, FIN
  } state_t;

  state_t             state, nxt_state;
  logic [PhW-1:0]     ph, nxt_ph;
  logic [ByteW-1:0]   byte_cnt, nxt_byte;
  logic [CoreW-1:0]   core_cnt, nxt_core;
  logic               aborting, nxt_abort;
  logic [7:0]         nxt_din;

  always_ff @(posedge CLK) begin
    if (PROGLOADER_RESET) begin
      state    <= IDLE;
      ph       <= '0;
      byte_cnt <= '0;
      core_cnt <= '0;
      aborting <= 1'b0;
    end else begin
      state    <= nxt_state;
      ph       <= nxt_ph;
      byte_cnt <= nxt_byte;
      core_cnt <= nxt_core;
      aborting <= nxt_abort;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_ph    = ph + 1'b1;
    nxt_byte  = byte_cnt;
    nxt_core  = core_cnt;
    nxt_abort = aborting;
    case (state)
      IDLE: begin
        nxt_ph = '0;
        if (PROGLOADER_START) begin
          nxt_state = PRST;
          nxt_byte  = '0;
          nxt_core  = '0;
          nxt_abort = 1'b0;
        end
      end
      // A normal programmer reset lasts two cycles; the abort variant only one.
      PRST: begin
        if (aborting || ph == PhW'(1)) begin
          nxt_ph    = '0;
          nxt_state = aborting ? IDLE : WAIT;
          nxt_abort = 1'b0;
        end
      end
      WAIT: begin
        nxt_ph = '0;
        if (PROGLOADER_VALID) nxt_state = SETUP;
      end
      SETUP:  if (ph == PhW'(SetupCycles - 1)) begin nxt_ph = '0; nxt_state = PSTRB;  end
      PSTRB:  if (ph == PhW'(StrobeWidth - 1)) begin nxt_ph = '0; nxt_state = HOLD;   end
      SSETUP: if (ph == PhW'(SetupCycles - 1)) begin nxt_ph = '0; nxt_state = SSTRB;  end
      SSTRB:  if (ph == PhW'(StrobeWidth - 1)) begin nxt_ph = '0; nxt_state = SHOLD;  end
      HOLD: begin
        if (ph == PhW'(HoldCycles - 1)) begin
          nxt_ph = '0;
          if (byte_cnt != ByteW'(RomDepth - 1)) begin
            nxt_byte  = byte_cnt + 1'b1;
            nxt_state = WAIT;
          end else if (core_cnt != CoreW'(NumberOfCores - 1)) begin
            nxt_byte  = '0;
            nxt_state = SSETUP;
          end else begin
            nxt_state = FIN;
          end
        end
      end
      SHOLD: begin
        if (ph == PhW'(HoldCycles - 1)) begin
          nxt_ph    = '0;
          nxt_core  = core_cnt + 1'b1;
          nxt_state = WAIT;
        end
      end
      FIN: begin
        nxt_ph    = '0;
        nxt_state = IDLE;
      end
      default: begin
        nxt_ph    = '0;
        nxt_state = IDLE;
      end
    endcase
    // Abort overrides everything except idle and the final done cycle.
    if (PROGLOADER_ABORT && state != IDLE && state != FIN) begin
      nxt_state = PRST;
      nxt_abort = 1'b1;
      nxt_ph    = '0;
      nxt_byte  = '0;
      nxt_core  = '0;
    end
  end

  always_comb begin
    nxt_din = PROGRAMMER_DIN;
    if (state == WAIT && nxt_state == SETUP)
      nxt_din = PROGLOADER_DATA;
    else if (nxt_state == SSETUP || nxt_state == IDLE || nxt_state == PRST)
      nxt_din = '0;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (PROGLOADER_RESET) begin
      PROGLOADER_READY <= 1'b0;
      PROGLOADER_BUSY  <= 1'b0;
      PROGLOADER_DONE  <= 1'b0;
      CPU_HOLD         <= 1'b0;
      PROGRAMMER_RESET <= 1'b0;
      PROGRAMMER_DIN   <= '0;
      PROGRAMMER_PCK   <= 1'b0;
      PROGRAMMER_SCK   <= 1'b0;
    end else begin
      PROGLOADER_READY <= (nxt_state == WAIT);
      PROGLOADER_BUSY  <= (nxt_state != IDLE);
      PROGLOADER_DONE  <= (nxt_state == FIN);
      CPU_HOLD         <= (nxt_state != IDLE);
      PROGRAMMER_RESET <= (nxt_state == PRST);
      PROGRAMMER_DIN   <= nxt_din;
      PROGRAMMER_PCK   <= (nxt_state == PSTRB);
      PROGRAMMER_SCK   <= (nxt_state == SSTRB);
    end
  end
endmodule

// File: tb/tb_program_loader_tx.sv
// Bench for program_loader_tx: scoreboard of host bytes against PCK-time DIN, strobe counting and timing.
`timescale 1ns/1ps
module tb_program_loader_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, valid;
  logic [7:0] data;
  logic       ready, busy, done, cpu_hold, prst, pck, sck;
  logic [7:0] din;
  logic       s_start, s_abort, s_valid;
  logic [7:0] s_data;
  logic       s_ready, s_busy, s_done, s_hold, s_prst, s_pck, s_sck;
  logic [7:0] s_din;

  program_loader_tx dut (
    .CLK(clk), .PROGLOADER_RESET(rst), .PROGLOADER_START(start), .PROGLOADER_ABORT(abort),
    .PROGLOADER_DATA(data), .PROGLOADER_VALID(valid), .PROGLOADER_READY(ready),
    .PROGLOADER_BUSY(busy), .PROGLOADER_DONE(done), .CPU_HOLD(cpu_hold),
    .PROGRAMMER_RESET(prst), .PROGRAMMER_DIN(din), .PROGRAMMER_PCK(pck), .PROGRAMMER_SCK(sck)
  );

  program_loader_tx #(.NumberOfCores(1), .RomDepth(4)) dut_small (
    .CLK(clk), .PROGLOADER_RESET(rst), .PROGLOADER_START(s_start), .PROGLOADER_ABORT(s_abort),
    .PROGLOADER_DATA(s_data), .PROGLOADER_VALID(s_valid), .PROGLOADER_READY(s_ready),
    .PROGLOADER_BUSY(s_busy), .PROGLOADER_DONE(s_done), .CPU_HOLD(s_hold),
    .PROGRAMMER_RESET(s_prst), .PROGRAMMER_DIN(s_din), .PROGRAMMER_PCK(s_pck), .PROGRAMMER_SCK(s_sck)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int pck_cnt, sck_cnt, done_cnt, prst_last, done_cyc, pck_w, sck_w, prst_w;
  int s_pck_cnt, s_sck_cnt, s_done_cnt;
  logic s_pck_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      pck_w = 0; sck_w = 0; prst_w = 0; s_pck_q = 1'b0;
    end else begin
      check("strobe_excl", 32'(pck & sck), 32'd0);
      check("ready_excl", 32'(ready & (pck | sck | prst | done)), 32'd0);
      if (pck && pck_w == 0) begin
        pck_cnt++;
        if (exp_q.size() == 0) check("pck_unexpected", 32'd1, 32'd0);
        else check("din", 32'(din), 32'(exp_q.pop_front()));
      end
      if (pck) pck_w++;
      else if (pck_w != 0) begin check("pck_width", 32'(pck_w), 32'd2); pck_w = 0; end
      if (sck && sck_w == 0) begin
        sck_cnt++;
        check("sck_pos", 32'(pck_cnt), 32'(16 * sck_cnt));
        check("sck_din", 32'(din), 32'd0);
      end
      if (sck) sck_w++;
      else if (sck_w != 0) begin check("sck_width", 32'(sck_w), 32'd2); sck_w = 0; end
      if (prst) prst_w++;
      else if (prst_w != 0) begin prst_last = prst_w; prst_w = 0; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (s_pck && !s_pck_q) begin
        check("s_din", 32'(s_din), 32'(8'hA0 + s_pck_cnt));
        s_pck_cnt++;
      end
      s_pck_q = s_pck;
      if (s_sck) s_sck_cnt++;
      if (s_done) s_done_cnt++;
    end
  end

  task automatic reset_counts();
    pck_cnt = 0; sck_cnt = 0; done_cnt = 0; prst_last = 0; done_cyc = 0;
  endtask

  task automatic send_bytes(input int n, input int base, input bit rnd);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data  = 8'(base + i);
      start = (rnd && $urandom_range(0, 15) == 0);
      if (valid && ready) begin exp_q.push_back(data); i++; end
    end
    if (i < n) check("send_timeout", 32'(i), 32'(n));
    @(negedge clk);
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done_sig(input string tag);
    int g = 0;
    while (!done && g < 2000) begin @(negedge clk); g++; end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic pulse_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int g;
    int start_cyc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; data = '0;
    s_start = 1'b0; s_abort = 1'b0; s_valid = 1'b0; s_data = '0;
    reset_counts();
    s_pck_cnt = 0; s_sck_cnt = 0; s_done_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({ready, busy, done, cpu_hold, prst, pck, sck, din}), 32'd0);
    check("rst_outs_small", 32'({s_ready, s_busy, s_done, s_hold, s_prst, s_pck, s_sck, s_din}), 32'd0);
    rst = 1'b0;

    // Full image, VALID held high; START during DONE must be ignored
    reset_counts();
    pulse_start(start_cyc);
    check("t1_hold_on_start", 32'({busy, cpu_hold, prst, ready}), 32'b1110);
    send_bytes(64, 0, 1'b0);
    wait_done_sig("t1_done_seen");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_done_width", 32'(done), 32'd0);
    check("t1_start_in_fin", 32'({busy, cpu_hold}), 32'd0);
    repeat (2) @(negedge clk);
    check("t1_idle", 32'({busy, prst}), 32'd0);
    check("t1_cycles", 32'(done_cyc - start_cyc), 32'd335);
    check("t1_prst_w", 32'(prst_last), 32'd2);
    check("t1_pck_cnt", 32'(pck_cnt), 32'd64);
    check("t1_sck_cnt", 32'(sck_cnt), 32'd3);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_queue", 32'(exp_q.size()), 32'd0);

    // Random VALID with stray START pulses while busy
    reset_counts();
    pulse_start(start_cyc);
    send_bytes(64, 8'h80, 1'b1);
    wait_done_sig("t2_done_seen");
    repeat (3) @(negedge clk);
    check("t2_pck_cnt", 32'(pck_cnt), 32'd64);
    check("t2_sck_cnt", 32'(sck_cnt), 32'd3);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_queue", 32'(exp_q.size()), 32'd0);
    check("t2_idle", 32'(busy), 32'd0);

    // Abort after 20 bytes, then a clean restart
    reset_counts();
    pulse_start(start_cyc);
    send_bytes(20, 8'h10, 1'b0);
    g = 0;
    while ((pck_cnt != 20 || pck) && g < 200) begin @(negedge clk); g++; end
    check("t3_pck20", 32'(pck_cnt), 32'd20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t3_prst_on", 32'(prst), 32'd1);
    @(negedge clk);
    check("t3_after", 32'({prst, busy, cpu_hold, done}), 32'd0);
    repeat (2) @(negedge clk);
    check("t3_prst_w", 32'(prst_last), 32'd1);
    check("t3_no_done", 32'(done_cnt), 32'd0);
    reset_counts();
    pulse_start(start_cyc);
    send_bytes(64, 8'h20, 1'b0);
    wait_done_sig("t3_restart_done");
    repeat (2) @(negedge clk);
    check("t3_restart_pck", 32'(pck_cnt), 32'd64);
    check("t3_restart_sck", 32'(sck_cnt), 32'd3);
    check("t3_restart_prst", 32'(prst_last), 32'd2);

    // Reset (with ABORT) during a PCK strobe
    reset_counts();
    pulse_start(start_cyc);
    send_bytes(1, 8'h5A, 1'b0);
    g = 0;
    while (!pck && g < 50) begin @(negedge clk); g++; end
    check("t4_in_pstrb", 32'(pck), 32'd1);
    rst = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_outs", 32'({ready, busy, done, cpu_hold, prst, pck, sck, din}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_idle", 32'({busy, prst, done}), 32'd0);

    // One core, four bytes
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    begin
      int i = 0;
      g = 0;
      while (i < 4 && g < 500) begin
        @(negedge clk);
        g++;
        s_valid = 1'b1;
        s_data  = 8'(8'hA0 + i);
        if (s_ready) i++;
      end
      @(negedge clk);
      s_valid = 1'b0;
    end
    g = 0;
    while (s_done_cnt == 0 && g < 200) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    check("t5_pck_cnt", 32'(s_pck_cnt), 32'd4);
    check("t5_sck_cnt", 32'(s_sck_cnt), 32'd0);
    check("t5_done_cnt", 32'(s_done_cnt), 32'd1);
    check("t5_idle", 32'(s_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
